pll_lock_monitor: RTL
=====================

Name: pll_lock_monitor

Overview:
- Sits directly downstream of the clock-generation PLL.
- Consumes the PLL's asynchronous locked output and drives its active-high reset input.
- Produces the synchronous-release system reset for logic running on one PLL output clock.
- Sequences PLL reset, lock wait with timeout/retry, a lock-stability qualification window, and lock-loss recovery; keeps saturating event counters for debug.

Parameters:
- SYNC_STAGES, 2, flops in the locked synchroniser (minimum 2)
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse
- LOCK_TIMEOUT, 65536, cycles to wait for lock before re-resetting the PLL
- STABLE_CYCLES, 1024, consecutive locked cycles required before releasing sys_rst_n
- CNT_W, 8, width of the saturating event counters

Ports:
- clk  in  1  monitor clock (free-running reference, not PLL-derived)
- rst_n  in  1  asynchronous active-low reset
- locked  in  1  PLL lock indicator, asynchronous to clk
- soft_restart  in  1  single-cycle request to re-run the full sequence
- clear_stats  in  1  single-cycle clear of counters and sticky flag
- pll_rst  out  1  active-high reset to PLL
- sys_rst_n  out  1  system reset, active-low
- ready  out  1  high while in RUN
- lock_lost  out  1  sticky: lock dropped while in RUN
- lost_cnt  out  CNT_W  saturating count of lock losses in RUN
- timeout_cnt  out  CNT_W  saturating count of lock timeouts
- state_o  out  2  current state encoding, for debug

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All flops, synchroniser included, clear on rst_n low.
- Reset values:
  - state = PLL_RST
  - pll_rst = 1, sys_rst_n = 0, ready = 0, lock_lost = 0
  - lost_cnt = 0, timeout_cnt = 0, internal counter = 0
- sys_rst_n asserts asynchronously with rst_n and deasserts only on a clk edge.
- locked passes through SYNC_STAGES flops to give locked_s. locked sampled high at edge k makes locked_s high after edge k+SYNC_STAGES-1.
- States: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3. One shared counter cnt, cleared on every state change.
  - PLL_RST: cnt increments each cycle. At cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly PLL_RST_CYCLES cycles after rst_n release.
  - WAIT_LOCK: if locked_s, go to STABLE. Otherwise, if cnt==LOCK_TIMEOUT-1, go to PLL_RST and increment timeout_cnt. Otherwise cnt++.
  - STABLE: if !locked_s, go to WAIT_LOCK with no counter update. If cnt==STABLE_CYCLES-1, go to RUN. Otherwise cnt++.
  - RUN: if !locked_s, go to PLL_RST, increment lost_cnt, and set lock_lost.
- Output timing: pll_rst, sys_rst_n and ready are registered decodes of next_state. Each changes on the same edge the state changes (pll_rst = next_state==PLL_RST; sys_rst_n = ready = next_state==RUN).
- Lock-release latency: locked first sampled high at edge k, held high, with the FSM in WAIT_LOCK → sys_rst_n rises at edge k+SYNC_STAGES+STABLE_CYCLES.
- soft_restart: from any state, next state is PLL_RST. No counter increments. It has priority over every other transition, including a lock-loss or timeout in the same cycle.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- clear_stats: clears lost_cnt, timeout_cnt and lock_lost. If an increment occurs in the same cycle, the result is 1 (or lock_lost=1), so the event is not lost.
- locked glitches shorter than the synchroniser delay may be missed; this is acceptable. Any locked_s low in STABLE restarts qualification.
- rst_n low mid-sequence: immediate return to reset values. A fresh PLL reset pulse is issued on release.

Decomposition:
- Shared clock/reset package holds:
  - state encoding constants (PLL_RST, WAIT_LOCK, STABLE, RUN)
  - default values of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, for reuse by the top level and the bench
- One sub-module: sync_bit (parameterised SYNC_STAGES, async active-low clear), reusable for other CDC single-bit inputs.
- FSM, counters and output registers stay in pll_lock_monitor.

Test Plan:
- Use overrides SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_W=2.
- Release rst_n with locked=0 → pll_rst high for exactly 4 edges then low. sys_rst_n stays 0. After 32 cycles in WAIT_LOCK, pll_rst re-pulses and timeout_cnt=1.
- Raise locked at edge k during WAIT_LOCK and hold → sys_rst_n=1 and ready=1 from edge k+10; state_o=3.
- Drop locked for 3 cycles midway through STABLE → state returns to WAIT_LOCK, sys_rst_n stays 0, no counter change. Re-raise locked → full 8-cycle qualification repeats.
- Drop locked in RUN → sys_rst_n=0 and pll_rst=1 at edge +2. lost_cnt increments and lock_lost=1. Repeat 5 times → lost_cnt saturates at 3.
- Pulse clear_stats in the same cycle as a lock-loss transition → lost_cnt=1, lock_lost=1. Pulse it alone → both 0.
- Pulse soft_restart in RUN → pll_rst=1 and sys_rst_n=0 next edge, counters unchanged. Assert rst_n low mid-STABLE → sys_rst_n=0 immediately (before next clk edge) and all outputs at reset values.

Source files
------------

// File: rtl/pll_lock_monitor_pkg.sv
// Shared definitions for the PLL lock monitor: FSM state encoding, default
// timing parameters and a small helper for sizing the shared cycle counter.
package pll_lock_monitor_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_CNT_W          = 8;

  // Largest of three terms, used to size a counter shared by several phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
// Reusable for any slow-changing single-bit input crossing into clk.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; oldest bit is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: pulses the PLL reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases the system reset. Lock loss in RUN
// restarts the whole sequence. Saturating debug counters record timeouts and
// lock losses.
module pll_lock_monitor
  import pll_lock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             soft_restart,
  input  logic             clear_stats,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [1:0]       state_o
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVT_MAX  = {CNT_W{1'b1}};

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          locked_s;
  logic          timeout_evt;
  logic          lost_evt;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (locked),
    .q    (locked_s)
  );

  // State register, shared phase counter and registered decodes of next_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      pll_rst   <= (next_state == PLL_RST);
      sys_rst_n <= (next_state == RUN);
      ready     <= (next_state == RUN);
    end
  end

  // Next-state logic; soft_restart overrides every other transition and event.
  always_comb begin
    next_state  = state;
    timeout_evt = 1'b0;
    lost_evt    = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          next_state = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          next_state  = PLL_RST;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state = PLL_RST;
          lost_evt   = 1'b1;
        end
      end
      default: next_state = PLL_RST;
    endcase
    if (soft_restart) begin
      next_state  = PLL_RST;
      timeout_evt = 1'b0;
      lost_evt    = 1'b0;
    end
    if (soft_restart || (next_state != state)) begin
      cnt_next = '0;
    end else if (state == RUN) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  // Saturating debug counters and sticky flag; a same-cycle event survives a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_cnt    <= '0;
      timeout_cnt <= '0;
      lock_lost   <= 1'b0;
    end else if (clear_stats) begin
      lost_cnt    <= lost_evt    ? CNT_W'(1) : '0;
      timeout_cnt <= timeout_evt ? CNT_W'(1) : '0;
      lock_lost   <= lost_evt;
    end else begin
      if (lost_evt && (lost_cnt != EVT_MAX)) lost_cnt <= lost_cnt + CNT_W'(1);
      if (timeout_evt && (timeout_cnt != EVT_MAX)) timeout_cnt <= timeout_cnt + CNT_W'(1);
      if (lost_evt) lock_lost <= 1'b1;
    end
  end

  assign state_o = state;

endmodule
